answer_judge: RTL and testbench
===============================

Name: answer_judge

Overview:
- Sits directly downstream of the answer-period stage.
- Consumes its one-cycle end-of-period pulse (postSig) and latches the player's switch answer and the generator's true symbol count.
- Judges the answer, updates the running score and round number, and drives the score/round seven-segment digits.
- Pulses nextRound to restart symbol generation until the game ends.

Parameters:
- NUM_ROUNDS, 5: rounds per game, range 1..15.
- RESULT_CYCLES, 100000000: cycles the result is held before advancing (1 s at 100 MHz), minimum 2.
- CNT_W, 8: width of the count and answer buses.

Ports:
- Clk100M  in  1  system clock, 100 MHz.
- Reset  in  1  synchronous, active-high reset.
- postSig  in  1  one-cycle pulse marking the end of the answer period.
- targetCount  in  CNT_W  true symbol count from the generator.
- playerAnswer  in  CNT_W  player's answer, switch value.
- newGame  in  1  level or pulse; clears the game.
- resultValid  out  1  high while in SHOW.
- answerCorrect  out  1  valid while resultValid is high.
- score  out  8  running score, saturating.
- roundNum  out  4  completed rounds.
- nextRound  out  1  one-cycle pulse requesting the next round.
- gameOver  out  1  high in DONE.
- scoreSeg0  out  8  score units digit.
- scoreSeg1  out  8  score tens digit.
- scoreSeg2  out  8  score hundreds digit.
- scoreSeg3  out  8  roundNum as a hex digit.

Behaviour:
- Clocking: single clock Clk100M; all registers update on its rising edge.
- Reset: synchronous, active-high, highest priority.
- Reset values:
  - state = IDLE.
  - score = 0, roundNum = 0.
  - resultValid, answerCorrect, nextRound, gameOver all 0.
  - All scoreSeg outputs = 8'hC0 (digit "0").
  - Hold counter = 0.
- Segment encoding:
  - Active-low; bit0..bit6 = segments a..g; bit7 = decimal point, always 1 (off).
  - Digits 0-F use the standard hex glyphs.
- States: IDLE, CAPTURE, SHOW, DONE.
- IDLE:
  - postSig high: latch targetCount and playerAnswer; go to CAPTURE.
  - Otherwise stay.
- CAPTURE, lasting one cycle:
  - Compare the latched values for equality.
  - Set answerCorrect to the result.
  - If correct, score += 1, saturating at 255.
  - roundNum += 1.
  - Go to SHOW.
  - Latency: with postSig in cycle N, resultValid, answerCorrect, score and roundNum are all visible at cycle N+2.
- SHOW:
  - resultValid = 1.
  - Hold counter counts RESULT_CYCLES-1 down to 0.
  - When the counter reaches 0 and roundNum == NUM_ROUNDS: go to DONE with gameOver = 1.
  - When the counter reaches 0 otherwise: nextRound = 1 for exactly one cycle and go to IDLE.
  - resultValid falls on the same edge that nextRound rises.
  - answerCorrect holds its value until the next CAPTURE.
- DONE:
  - gameOver = 1; score and roundNum frozen.
  - Leaves only on newGame or Reset.
- postSig outside IDLE (CAPTURE, SHOW or DONE): ignored and not queued.
- newGame, any state, when Reset is low:
  - Next cycle: state = IDLE.
  - score, roundNum, answerCorrect, resultValid, gameOver cleared.
  - nextRound = 1 for one cycle, to start the first round.
  - newGame held high: the block stays in IDLE and pulses nextRound only on the first cycle.
- postSig and newGame in the same cycle: newGame wins; the answer is discarded.
- Display path:
  - score is converted to BCD hundreds/tens/units combinationally.
  - Each digit and roundNum is encoded to segments and registered.
  - Segment outputs lag score/roundNum by one cycle.
- Width rule: the comparison is over the full CNT_W bits; there is no truncation.

Optional Feature:
- Macro: STREAK_BONUS_EN.
- Defined:
  - A 2-bit streak counter increments on each correct answer, saturating at 3, and clears on a wrong answer or newGame.
  - On a correct answer with a prior streak ≥ 2, i.e. the third and later consecutive correct answers, score += 2 instead of 1, still saturating at 255.
- Undefined: every correct answer adds 1 and no streak register exists.

Decomposition:
- Shared package (symcounter_pkg):
  - State enum: IDLE, CAPTURE, SHOW, DONE.
  - SEG_OFF = 8'hFF.
  - The hex-to-segment glyph constant table.
  - Default CNT_W.
- Sub-module: seg7_encode, a 4-bit value to 8-bit active-low pattern.
  - Combinational; instantiated four times.
  - Reusable by the answer-period and generator displays.

Test Plan (all with RESULT_CYCLES = 4, NUM_ROUNDS = 3):
- Correct answer: Reset, then postSig with target=7, answer=7 → at N+2 resultValid=1, answerCorrect=1, score=1, roundNum=1; nextRound pulses once 4 cycles later; scoreSeg0=8'hF9.
- Wrong answer: postSig with target=9, answer=8 → answerCorrect=0, score unchanged, roundNum increments.
- Game end: three rounds (correct, wrong, correct) → score=2, roundNum=3, gameOver=1, no nextRound after round 3; a further postSig is ignored.
- postSig while in SHOW → no effect on score or round; no queued capture.
- newGame in the same cycle as postSig during DONE → next cycle all cleared, nextRound single pulse, the answer is discarded, scoreSeg0..2 = 8'hC0.
- STREAK_BONUS_EN defined: four consecutive correct answers with NUM_ROUNDS = 4 → score = 1, 2, 4, 6; a wrong answer then resets the bonus.

Source files
------------

// File: rtl/symcounter_pkg.sv
// ---------------------------------------------------------------------------
// symcounter_pkg : shared states, segment glyphs and defaults for the game.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package symcounter_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHOW    = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE    = 2'(IDLE);
  localparam logic [1:0] ST_CAPTURE = 2'(CAPTURE);
  localparam logic [1:0] ST_SHOW    = 2'(SHOW);
  localparam logic [1:0] ST_DONE    = 2'(DONE);

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low glyphs, bit0..6 = a..g, bit7 = decimal point (kept off)
  localparam logic [7:0] SEG_GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

`default_nettype wire

// File: rtl/answer_judge_if.sv
// ---------------------------------------------------------------------------
// answer_judge_if : answer-period handshake in, score/round/display out.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface answer_judge_if
  import symcounter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             postSig;
  logic [CNT_W-1:0] targetCount;
  logic [CNT_W-1:0] playerAnswer;
  logic             newGame;

  logic             resultValid;
  logic             answerCorrect;
  logic [7:0]       score;
  logic [3:0]       roundNum;
  logic             nextRound;
  logic             gameOver;
  logic [7:0]       scoreSeg0;
  logic [7:0]       scoreSeg1;
  logic [7:0]       scoreSeg2;
  logic [7:0]       scoreSeg3;

  modport master (
    output postSig, targetCount, playerAnswer, newGame,
    input  resultValid, answerCorrect, score, roundNum, nextRound, gameOver,
    input  scoreSeg0, scoreSeg1, scoreSeg2, scoreSeg3
  );

  modport slave (
    input  postSig, targetCount, playerAnswer, newGame,
    output resultValid, answerCorrect, score, roundNum, nextRound, gameOver,
    output scoreSeg0, scoreSeg1, scoreSeg2, scoreSeg3
  );
endinterface

`default_nettype wire

// File: rtl/seg7_encode.sv
// ---------------------------------------------------------------------------
// seg7_encode : 4-bit value to active-low 7-segment pattern, optional blank.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_encode
  import symcounter_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  assign seg_o = blank_i ? SEG_OFF : SEG_GLYPH[value_i];

endmodule

`default_nettype wire

// File: rtl/answer_judge.sv
// ---------------------------------------------------------------------------
// answer_judge : judges each answer, keeps score/round, drives score digits.
// Optional build macro: STREAK_BONUS_EN (streak bonus scoring). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module answer_judge
  import symcounter_pkg::*;
#(
  parameter int NUM_ROUNDS    = 5,
  parameter int RESULT_CYCLES = 100000000,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic          Clk100M,
  input  logic          Reset,
  answer_judge_if.slave bus
);

  localparam int         HOLD_W      = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESULT_CYCLES - 1);
  localparam logic [3:0] LAST_ROUND  = 4'(NUM_ROUNDS);

  logic [1:0]        state_q,   state_d;
  logic [CNT_W-1:0]  target_q,  target_d;
  logic [CNT_W-1:0]  answer_q,  answer_d;
  logic [7:0]        score_q,   score_d;
  logic [3:0]        round_q,   round_d;
  logic              correct_q, correct_d;
  logic              valid_q,   valid_d;
  logic              next_q,    next_d;
  logic              over_q,    over_d;
  logic [HOLD_W-1:0] hold_q,    hold_d;
  logic              ngprev_q,  ngprev_d;

  logic              is_match;
  logic [1:0]        score_inc;
  logic [8:0]        score_sum;

  assign is_match  = (target_q == answer_q);
  assign score_sum = {1'b0, score_q} + {7'd0, score_inc};

`ifdef STREAK_BONUS_EN
  logic [1:0] streak_q, streak_d;

  // Third and later consecutive correct answers are worth two points
  assign score_inc = (streak_q >= 2'd2) ? 2'd2 : 2'd1;

  always_comb begin
    streak_d = streak_q;
    if (bus.newGame) begin
      streak_d = 2'd0;
    end else if (state_q == ST_CAPTURE) begin
      if (!is_match)
        streak_d = 2'd0;
      else if (streak_q != 2'd3)
        streak_d = streak_q + 2'd1;
    end
  end

  always_ff @(posedge Clk100M) begin
    if (Reset) streak_q <= 2'd0;
    else       streak_q <= streak_d;
  end
`else
  assign score_inc = 2'd1;
`endif

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    answer_d  = answer_q;
    score_d   = score_q;
    round_d   = round_q;
    correct_d = correct_q;
    valid_d   = valid_q;
    next_d    = 1'b0;
    over_d    = over_q;
    hold_d    = hold_q;
    ngprev_d  = bus.newGame;

    if (bus.newGame) begin
      state_d   = ST_IDLE;
      score_d   = 8'd0;
      round_d   = 4'd0;
      correct_d = 1'b0;
      valid_d   = 1'b0;
      over_d    = 1'b0;
      hold_d    = '0;
      next_d    = ~ngprev_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.postSig) begin
            target_d = bus.targetCount;
            answer_d = bus.playerAnswer;
            state_d  = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          correct_d = is_match;
          if (is_match)
            score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
          round_d = round_q + 4'd1;
          hold_d  = HOLD_LOAD;
          valid_d = 1'b1;
          state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (hold_q == '0) begin
            valid_d = 1'b0;
            if (round_q == LAST_ROUND) begin
              over_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              next_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        ST_DONE: over_d = 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      answer_q  <= '0;
      score_q   <= 8'd0;
      round_q   <= 4'd0;
      correct_q <= 1'b0;
      valid_q   <= 1'b0;
      next_q    <= 1'b0;
      over_q    <= 1'b0;
      hold_q    <= '0;
      ngprev_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      answer_q  <= answer_d;
      score_q   <= score_d;
      round_q   <= round_d;
      correct_q <= correct_d;
      valid_q   <= valid_d;
      next_q    <= next_d;
      over_q    <= over_d;
      hold_q    <= hold_d;
      ngprev_q  <= ngprev_d;
    end
  end

  // Display path: digits 0..2 are score BCD, digit 3 is the round in hex
  logic [3:0] digit [4];
  logic [7:0] seg_d [4];
  logic [7:0] seg_q [4];

  always_comb begin
    digit[0] = 4'(score_q % 8'd10);
    digit[1] = 4'((score_q / 8'd10) % 8'd10);
    digit[2] = 4'(score_q / 8'd100);
    digit[3] = round_q;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_seg
    seg7_encode u_enc (
      .value_i (digit[gi]),
      .blank_i (1'b0),
      .seg_o   (seg_d[gi])
    );
  end

  always_ff @(posedge Clk100M) begin
    for (int i = 0; i < 4; i++) begin
      if (Reset) seg_q[i] <= SEG_GLYPH[0];
      else       seg_q[i] <= seg_d[i];
    end
  end

  assign bus.resultValid   = valid_q;
  assign bus.answerCorrect = correct_q;
  assign bus.score         = score_q;
  assign bus.roundNum      = round_q;
  assign bus.nextRound     = next_q;
  assign bus.gameOver      = over_q;
  assign bus.scoreSeg0     = seg_q[0];
  assign bus.scoreSeg1     = seg_q[1];
  assign bus.scoreSeg2     = seg_q[2];
  assign bus.scoreSeg3     = seg_q[3];

endmodule

`default_nettype wire

// File: tb/tb_answer_judge.sv
// ---------------------------------------------------------------------------
// tb_answer_judge : directed rounds against a timeline model of the judge.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_answer_judge;

  localparam int RC = 4;
`ifdef STREAK_BONUS_EN
  localparam int NR = 4;
`else
  localparam int NR = 3;
`endif

  localparam logic [7:0] GLY [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic clk;
  logic rst;

  answer_judge_if #(.CNT_W(8)) bus ();

  answer_judge #(
    .NUM_ROUNDS    (NR),
    .RESULT_CYCLES (RC),
    .CNT_W         (8)
  ) dut (
    .Clk100M (clk),
    .Reset   (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Timeline model: an accepted answer shows its verdict one edge after capture,
  // stays visible for RC cycles, then either requests a round or ends the game.
  int m_init = 0;
  int m_score, m_round, m_corr, m_valid, m_next, m_over;
  int m_busy, m_k, m_lt, m_la, m_ngp, m_streak;
  int m_seg [4];

  initial begin
    forever begin
      @(negedge clk);
      if (m_init != 0) begin
        check("resultValid",   bus.resultValid,   m_valid);
        check("answerCorrect", bus.answerCorrect, m_corr);
        check("score",         bus.score,         m_score);
        check("roundNum",      bus.roundNum,      m_round);
        check("nextRound",     bus.nextRound,     m_next);
        check("gameOver",      bus.gameOver,      m_over);
        check("scoreSeg0",     bus.scoreSeg0,     m_seg[0]);
        check("scoreSeg1",     bus.scoreSeg1,     m_seg[1]);
        check("scoreSeg2",     bus.scoreSeg2,     m_seg[2]);
        check("scoreSeg3",     bus.scoreSeg3,     m_seg[3]);
      end
      if (rst) begin
        m_init = 1; m_score = 0; m_round = 0; m_corr = 0; m_valid = 0;
        m_next = 0; m_over = 0; m_busy = 0; m_k = 0; m_ngp = 0; m_streak = 0;
        for (int i = 0; i < 4; i++) m_seg[i] = 'hC0;
      end else begin
        m_seg[0] = GLY[m_score % 10];
        m_seg[1] = GLY[(m_score / 10) % 10];
        m_seg[2] = GLY[m_score / 100];
        m_seg[3] = GLY[m_round];
        m_next = 0;
        if (bus.newGame) begin
          m_score = 0; m_round = 0; m_corr = 0; m_valid = 0; m_over = 0;
          m_busy = 0; m_streak = 0;
          m_next = (m_ngp == 0) ? 1 : 0;
        end else if (m_busy != 0) begin
          m_k++;
          if (m_k == 1) begin
            m_corr = (m_lt == m_la) ? 1 : 0;
            if (m_corr != 0) begin
`ifdef STREAK_BONUS_EN
              m_score += (m_streak >= 2) ? 2 : 1;
              m_streak = (m_streak < 3) ? m_streak + 1 : 3;
`else
              m_score += 1;
`endif
              if (m_score > 255) m_score = 255;
            end else begin
              m_streak = 0;
            end
            m_round++;
            m_valid = 1;
          end else if (m_k == RC + 1) begin
            m_valid = 0;
            m_busy = 0;
            if (m_round == NR) m_over = 1;
            else               m_next = 1;
          end
        end else if (m_over == 0 && bus.postSig) begin
          m_lt = bus.targetCount;
          m_la = bus.playerAnswer;
          m_busy = 1;
          m_k = 0;
        end
        m_ngp = bus.newGame ? 1 : 0;
      end
    end
  end

  // One full round starting from IDLE; returns after resultValid falls.
  task automatic play_round(input logic [7:0] t, input logic [7:0] a,
                            input int exp_score, input int exp_round);
    int n;
    bus.postSig = 1'b1; bus.targetCount = t; bus.playerAnswer = a;
    tick();
    bus.postSig = 1'b0;
    tick();
    check("lit_valid_n2",   bus.resultValid,   1);
    check("lit_correct_n2", bus.answerCorrect, (t == a) ? 1 : 0);
    check("lit_score_n2",   bus.score,         exp_score);
    check("lit_round_n2",   bus.roundNum,      exp_round);
    n = 0;
    while (bus.resultValid === 1'b1 && n < RC + 4) begin
      tick();
      n++;
    end
    check("lit_show_len", n, RC);
  endtask

  task automatic new_game_pulse();
    bus.newGame = 1'b1;
    tick();
    bus.newGame = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.postSig = 1'b0; bus.newGame = 1'b0;
    bus.targetCount = '0; bus.playerAnswer = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("lit_rst_valid", bus.resultValid, 0);
    check("lit_rst_score", bus.score,       0);
    check("lit_rst_round", bus.roundNum,    0);
    check("lit_rst_seg0",  bus.scoreSeg0,   8'hC0);
    check("lit_rst_seg3",  bus.scoreSeg3,   8'hC0);
    check("lit_rst_over",  bus.gameOver,    0);

`ifdef STREAK_BONUS_EN
    play_round(8'd1, 8'd1, 1, 1);
    play_round(8'd2, 8'd2, 2, 2);
    play_round(8'd3, 8'd3, 4, 3);
    play_round(8'd4, 8'd4, 6, 4);
    check("lit_streak_over", bus.gameOver, 1);
    new_game_pulse();
    play_round(8'd5, 8'd5, 1, 1);
    play_round(8'd6, 8'd6, 2, 2);
    play_round(8'd7, 8'd8, 2, 3);
    play_round(8'd9, 8'd9, 3, 4);
    check("lit_streak_score", bus.score, 3);
`else
    // Round 1: correct
    play_round(8'd7, 8'd7, 1, 1);
    check("lit_next_r1", bus.nextRound, 1);
    check("lit_seg0_r1", bus.scoreSeg0, 8'hF9);
    tick();
    check("lit_next_once", bus.nextRound, 0);

    // Round 2: wrong, with a stray postSig while the result is shown
    bus.postSig = 1'b1; bus.targetCount = 8'd9; bus.playerAnswer = 8'd8;
    tick();
    bus.postSig = 1'b0;
    tick();
    check("lit_r2_correct", bus.answerCorrect, 0);
    check("lit_r2_score",   bus.score,         1);
    check("lit_r2_round",   bus.roundNum,      2);
    bus.postSig = 1'b1; bus.targetCount = 8'd5; bus.playerAnswer = 8'd5;
    tick();
    bus.postSig = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("lit_r2_next", bus.nextRound, 1);
    tick(); tick(); tick();
    check("lit_no_queue_valid", bus.resultValid, 0);
    check("lit_no_queue_round", bus.roundNum,    2);

    // Round 3: correct, game ends
    play_round(8'd3, 8'd3, 2, 3);
    check("lit_over",    bus.gameOver,  1);
    check("lit_no_next", bus.nextRound, 0);
    bus.postSig = 1'b1; bus.targetCount = 8'd4; bus.playerAnswer = 8'd4;
    tick();
    bus.postSig = 1'b0;
    tick(); tick();
    check("lit_done_score", bus.score,    2);
    check("lit_done_round", bus.roundNum, 3);

    // newGame together with postSig in DONE
    bus.newGame = 1'b1; bus.postSig = 1'b1;
    bus.targetCount = 8'd1; bus.playerAnswer = 8'd1;
    tick();
    bus.postSig = 1'b0;
    check("lit_ng_score", bus.score,     0);
    check("lit_ng_round", bus.roundNum,  0);
    check("lit_ng_over",  bus.gameOver,  0);
    check("lit_ng_next",  bus.nextRound, 1);
    tick();
    check("lit_ng_hold_next", bus.nextRound, 0);
    check("lit_ng_seg0", bus.scoreSeg0, 8'hC0);
    check("lit_ng_seg1", bus.scoreSeg1, 8'hC0);
    check("lit_ng_seg2", bus.scoreSeg2, 8'hC0);
    tick();
    bus.newGame = 1'b0;
    tick();
    check("lit_ng_idle", bus.resultValid, 0);

    // Full-width comparison: values differing only in the top bit
    play_round(8'hFF, 8'h7F, 0, 1);
    play_round(8'h80, 8'h80, 1, 2);
    play_round(8'h00, 8'h80, 1, 3);
    check("lit_w_over", bus.gameOver,  1);
    check("lit_w_seg3", bus.scoreSeg3, 8'hB0);
    new_game_pulse();
    play_round(8'h12, 8'h12, 1, 1);
`endif

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
